f8_alu: RTL and testbench
=========================

// Module: f8_alu
// PURPOSE
// - Arithmetic/logic unit of the f8 CPU datapath. Computes 8-bit and 16-bit results and the C/Z/N flags
//   for the opcode selected by the decoder.
// - Datapath is combinational: results are consumed by the register file, data-memory write port and SP
//   in the same cycle.
// - One registered copy of the last result (result_q) is provided for trace and debug.
// PARAMETERS
// - none (data width fixed at 16 bits; byte ops use bits [7:0])
// PORTS
// clk         in   1   clock; result_q updates on rising edge
// reset_n     in   1   asynchronous, active-low reset
// aluinst     in   5   operation select (aluinst_t encoding, see BEHAVIOUR)
// op0         in   16  first operand (accumulator / source)
// op1         in   16  second operand
// op2         in   16  reserved, ignored
// c_in        in   1   carry flag in (ADC, SBC, RRC, RLC)
// swapop_in   in   1   1 = exchange op0 and op1 before the operation
// result_reg  out  16  result to SP/register path
// result_mem  out  16  result to register file / memory write; always equal to result_reg
// c_out       out  1   carry out
// z_out       out  1   zero flag
// n_out       out  1   negative flag
// result_q    out  16  result_reg registered on clk
// BEHAVIOUR
// - Swap: a = swapop_in ? op1 : op0, b = swapop_in ? op0 : op1; all ops use a, b.
// - Encoding (5-bit):
//   PASS0=0, PASSW0=1, ADD=2, ADC=3, SUB=4, SBC=5, AND=6, OR=7, XOR=8, SRL=9, SLL=10,
//   RRC=11, RLC=12, INC=13, DEC=14, SUBW=15, SEX=16; all other codes act as PASS0.
// - 8-bit ops: result[15:8]=8'h00 and result[7:0] computed from a[7:0], b[7:0].
//   z_out = (result[7:0]==0); n_out = result[7].
// - 16-bit ops (PASSW0, SUBW, SEX): result uses all 16 bits. z_out = (result==0); n_out = result[15].
// - ADD: a+b. ADC: a+b+c_in. c_out = carry out of bit 7.
// - SUB: a+~b+1. SBC: a+~b+c_in. c_out = carry out of bit 7, so c_out=1 means no borrow.
//   CP is issued as SUB; the result is discarded by the CPU.
// - SUBW: 16-bit a+~b+1; c_out = carry out of bit 15 (1 = no borrow).
// - AND/OR/XOR: bitwise on [7:0]; c_out=0.
// - SRL: result={0,a[7:1]}, c_out=a[0]. SLL: result={a[6:0],0}, c_out=a[7].
// - RRC: result={c_in,a[7:1]}, c_out=a[0]. RLC: result={a[6:0],c_in}, c_out=a[7].
// - INC: a+1, c_out = carry out of bit 7 (1 only for 0xFF).
//   DEC: a+0xFF, c_out = carry out of bit 7 (0 only for 0x00).
// - PASS0: result={8'h00,a[7:0]}, c_out=0. PASSW0: result=a, c_out=0. SEX: result={{8{a[7]}},a[7:0]}, c_out=0.
// - Flags are always driven; the CPU decides which flags it latches.
// - No X propagation: with X on unused operand bytes, outputs depend only on the bits defined above.
// - result_q: async clear to 16'h0000 while reset_n=0; otherwise result_q <= result_reg on each rising clk.
// - Reset values: result_q=0. All other outputs are combinational and are not affected by reset.
// - Latency: 0 cycles for results and flags; 1 cycle for result_q.
// TESTING
// - ADD: a=0x00F0, b=0x0010 -> result 0x0000, c=1, z=1, n=0. ADC with c_in=1, 0x7F+0x00 -> 0x80, c=0, n=1.
// - SUB/SBC: 0x05-0x06 -> 0xFF, c=0, n=1. SBC 0x05-0x05 with c_in=0 -> 0xFF, c=0.
//   SUB 0x05-0x05 -> 0x00, c=1, z=1.
// - Shifts/rotates on 0x81: SRL -> 0x40, c=1; SLL -> 0x02, c=1; RRC c_in=0 -> 0x40, c=1;
//   RLC c_in=1 -> 0x03, c=1.
// - 16-bit: SUBW 0x0100-0x0201 -> 0xFEFF, c=0, n=1; SEX 0x0080 -> 0xFF80;
//   PASSW0 swapop_in=1, op1=0xAA55 -> 0xAA55.
// - INC 0xFF -> 0x00, c=1, z=1; DEC 0x00 -> 0xFF, c=0, n=1. Logic: AND 0xF0&0x0F -> 0x00, z=1, c=0.
// - reset_n low mid-stream -> result_q=0 at once, without waiting for clk. After release, result_q follows
//   result_reg one clk later.

Source files
------------

// File: rtl/f8_alu.sv
// f8 CPU arithmetic/logic unit: combinational 8/16-bit result and C/Z/N flags,
// plus a registered copy of the last result for trace.
module f8_alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  aluinst,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic        c_in,
  input  logic        swapop_in,
  output logic [15:0] result_reg,
  output logic [15:0] result_mem,
  output logic        c_out,
  output logic        z_out,
  output logic        n_out,
  output logic [15:0] result_q
);

  typedef enum logic [4:0] {
    ALU_PASS0  = 5'd0,
    ALU_PASSW0 = 5'd1,
    ALU_ADD    = 5'd2,
    ALU_ADC    = 5'd3,
    ALU_SUB    = 5'd4,
    ALU_SBC    = 5'd5,
    ALU_AND    = 5'd6,
    ALU_OR     = 5'd7,
    ALU_XOR    = 5'd8,
    ALU_SRL    = 5'd9,
    ALU_SLL    = 5'd10,
    ALU_RRC    = 5'd11,
    ALU_RLC    = 5'd12,
    ALU_INC    = 5'd13,
    ALU_DEC    = 5'd14,
    ALU_SUBW   = 5'd15,
    ALU_SEX    = 5'd16
  } aluinst_t;

  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [8:0]  sum8;
  logic [16:0] sum16;
  logic [15:0] res;
  logic        carry;
  logic        wide;

  // op2 is reserved by the decoder and intentionally not used
  logic unused_op2;
  assign unused_op2 = ^op2;

  assign a  = swapop_in ? op1 : op0;
  assign b  = swapop_in ? op0 : op1;
  assign a8 = a[7:0];
  assign b8 = b[7:0];

  always_comb begin
    res   = 16'h0000;
    carry = 1'b0;
    wide  = 1'b0;
    sum8  = 9'h000;
    sum16 = 17'h00000;
    case (aluinst)
      ALU_PASSW0: begin
        res  = a;
        wide = 1'b1;
      end
      ALU_ADD: sum8 = {1'b0, a8} + {1'b0, b8};
      ALU_ADC: sum8 = {1'b0, a8} + {1'b0, b8} + {8'h00, c_in};
      ALU_SUB: sum8 = {1'b0, a8} + {1'b0, ~b8} + 9'd1;
      ALU_SBC: sum8 = {1'b0, a8} + {1'b0, ~b8} + {8'h00, c_in};
      ALU_AND: res[7:0] = a8 & b8;
      ALU_OR:  res[7:0] = a8 | b8;
      ALU_XOR: res[7:0] = a8 ^ b8;
      ALU_SRL: begin
        res[7:0] = {1'b0, a8[7:1]};
        carry    = a8[0];
      end
      ALU_SLL: begin
        res[7:0] = {a8[6:0], 1'b0};
        carry    = a8[7];
      end
      ALU_RRC: begin
        res[7:0] = {c_in, a8[7:1]};
        carry    = a8[0];
      end
      ALU_RLC: begin
        res[7:0] = {a8[6:0], c_in};
        carry    = a8[7];
      end
      ALU_INC: sum8 = {1'b0, a8} + 9'd1;
      ALU_DEC: sum8 = {1'b0, a8} + 9'h0FF;
      ALU_SUBW: begin
        sum16 = {1'b0, a} + {1'b0, ~b} + 17'd1;
        res   = sum16[15:0];
        carry = sum16[16];
        wide  = 1'b1;
      end
      ALU_SEX: begin
        res  = {{8{a8[7]}}, a8};
        wide = 1'b1;
      end
      default: res[7:0] = a8;
    endcase

    // byte arithmetic shares one 9-bit adder result
    case (aluinst)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_INC, ALU_DEC: begin
        res   = {8'h00, sum8[7:0]};
        carry = sum8[8];
      end
      default: ;
    endcase
  end

  assign result_reg = res;
  assign result_mem = res;
  assign c_out      = carry;
  assign z_out      = wide ? (res == 16'h0000) : (res[7:0] == 8'h00);
  assign n_out      = wide ? res[15] : res[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) result_q <= 16'h0000;
    else          result_q <= res;
  end

endmodule

// File: tb/tb_f8_alu.sv
// Directed scoreboard bench for f8_alu: expected results are queued at drive
// time and popped when the combinational outputs and result_q are sampled.
module tb_f8_alu;

  logic        clk;
  logic        reset_n;
  logic [4:0]  aluinst;
  logic [15:0] op0;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        c_in;
  logic        swapop_in;
  logic [15:0] result_reg;
  logic [15:0] result_mem;
  logic        c_out;
  logic        z_out;
  logic        n_out;
  logic [15:0] result_q;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  f8_alu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .aluinst    (aluinst),
    .op0        (op0),
    .op1        (op1),
    .op2        (op2),
    .c_in       (c_in),
    .swapop_in  (swapop_in),
    .result_reg (result_reg),
    .result_mem (result_mem),
    .c_out      (c_out),
    .z_out      (z_out),
    .n_out      (n_out),
    .result_q   (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [15:0] a0,
                      input logic [15:0] a1, input logic ci, input logic sw,
                      input logic [15:0] er, input logic ec, input logic ez, input logic en);
    exp_t e;
    @(negedge clk);
    aluinst   = op;
    op0       = a0;
    op1       = a1;
    op2       = 16'($urandom);
    c_in      = ci;
    swapop_in = sw;
    e.tag = tag; e.res = er; e.c = ec; e.z = ez; e.n = en;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".res"}, result_reg, e.res);
      check({e.tag, ".mem"}, result_mem, e.res);
      check({e.tag, ".c"}, {15'h0, c_out}, {15'h0, e.c});
      check({e.tag, ".z"}, {15'h0, z_out}, {15'h0, e.z});
      check({e.tag, ".n"}, {15'h0, n_out}, {15'h0, e.n});
      @(posedge clk);
      #1;
      check({e.tag, ".q"}, result_q, e.res);
    end
  endtask

  initial begin
    aluinst = 5'd0; op0 = 16'h0; op1 = 16'h0; op2 = 16'h0;
    c_in = 1'b0; swapop_in = 1'b0;
    reset_n = 1'b0;
    #3;
    check("reset_q", result_q, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    //    tag        op     op0       op1       cin   swp   result    c     z     n
    step("add",      5'd2,  16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step("add_hi",   5'd2,  16'h12F0, 16'h3410, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step("adc",      5'd3,  16'h007F, 16'h0000, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1);
    step("adc_wrap", 5'd3,  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step("sub_brw",  5'd4,  16'h0005, 16'h0006, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1);
    step("sbc",      5'd5,  16'h0005, 16'h0005, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1);
    step("sub_eq",   5'd4,  16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step("sub_swap", 5'd4,  16'h0006, 16'h0005, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1);
    step("srl",      5'd9,  16'h0081, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b0);
    step("sll",      5'd10, 16'h0081, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    step("rrc",      5'd11, 16'h0081, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b0);
    step("rrc_ci",   5'd11, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0081, 1'b0, 1'b0, 1'b1);
    step("rlc",      5'd12, 16'h0081, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    step("subw",     5'd15, 16'h0100, 16'h0201, 1'b0, 1'b0, 16'hFEFF, 1'b0, 1'b0, 1'b1);
    step("subw_nb",  5'd15, 16'h0300, 16'h0201, 1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0);
    step("sex",      5'd16, 16'h0080, 16'h0000, 1'b0, 1'b0, 16'hFF80, 1'b0, 1'b0, 1'b1);
    step("passw0",   5'd1,  16'h1234, 16'hAA55, 1'b0, 1'b1, 16'hAA55, 1'b0, 1'b0, 1'b1);
    step("inc",      5'd13, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step("dec",      5'd14, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1);
    step("dec_one",  5'd14, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step("and",      5'd6,  16'h00F0, 16'h000F, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step("or",       5'd7,  16'h00A0, 16'h0005, 1'b0, 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b1);
    step("xor",      5'd8,  16'hFFFF, 16'h000F, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1);
    step("pass0",    5'd0,  16'h1280, 16'h0000, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1);
    step("illegal",  5'd31, 16'hAB34, 16'h0000, 1'b0, 1'b0, 16'h0034, 1'b0, 1'b0, 1'b0);
    step("add_x",    5'd2,  16'hxx05, 16'hxx03, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);

    // asynchronous clear mid-stream: result_q nonzero, then drops without a clock edge
    step("pre_rst",  5'd1,  16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_q", result_q, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_q", result_q, 16'h0000);
    check("rst_comb", result_reg, 16'hBEEF);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_q_wait", result_q, 16'h0000);
    step("post_rst", 5'd2, 16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
